// File: rtl/c499_key_loader.sv
// c499_key_loader: receives a serial key frame, verifies its XOR-fold checksum and drives the c499 key inputs
module c499_key_loader #(
    parameter int KEY_W    = 27,
    parameter int CHK_W    = 8,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             bit_valid_i,
    input  logic             bit_data_i,
    output logic             bit_ready_o,
    output logic [3:0]       key_p_o,
    output logic [KEY_W-5:0] key_x_o,
    output logic             key_valid_o,
    output logic             busy_o,
    output logic             err_o,
    output logic             lockout_o,
    output logic [3:0]       fail_cnt_o
);
    localparam int FRAME_W = KEY_W + CHK_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int NCHUNK  = (KEY_W + CHK_W - 1) / CHK_W;

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, ARMED, LOCKOUT} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_W-1:0]      frame_q, frame_d;
    logic [KEY_W-1:0]        key_q, key_d;
    logic                    key_valid_q, key_valid_d;
    logic                    err_q, err_d;
    logic [3:0]              fail_q, fail_d;
    logic [NCHUNK*CHK_W-1:0] key_pad;
    logic [CHK_W-1:0]        calc;
    logic [3:0]              fail_inc;
    logic                    beat;

    assign beat        = bit_valid_i && (state_q == LOAD);
    assign fail_inc    = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
    assign bit_ready_o = (state_q == LOAD);
    assign busy_o      = (state_q == LOAD) || (state_q == CHECK);
    assign lockout_o   = (state_q == LOCKOUT);
    assign key_p_o     = key_q[3:0];
    assign key_x_o     = key_q[KEY_W-1:4];
    assign key_valid_o = key_valid_q;
    assign err_o       = err_q;
    assign fail_cnt_o  = fail_q;

    // XOR-fold of the received key in CHK_W chunks, top chunk zero-padded
    always_comb begin
        key_pad              = '0;
        key_pad[KEY_W-1:0]   = frame_q[KEY_W-1:0];
        calc                 = '0;
        for (int k = 0; k < NCHUNK; k++) calc = calc ^ key_pad[k*CHK_W +: CHK_W];
    end

    // Next-state and registered-output logic; clear outranks start and the checksum verdict
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        err_d       = 1'b0;
        fail_d      = fail_q;
        if (clear_i && state_q != LOCKOUT) begin
            state_d     = IDLE;
            cnt_d       = '0;
            frame_d     = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    frame_d = '0;
                end
                LOAD: if (beat) begin
                    frame_d[cnt_q] = bit_data_i;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(FRAME_W - 1)) state_d = CHECK;
                end
                CHECK: if (calc == frame_q[FRAME_W-1 -: CHK_W]) begin
                    state_d     = ARMED;
                    key_d       = frame_q[KEY_W-1:0];
                    key_valid_d = 1'b1;
                    fail_d      = '0;
                end else begin
                    err_d   = 1'b1;
                    fail_d  = fail_inc;
                    state_d = (fail_inc == 4'(MAX_FAIL)) ? LOCKOUT : IDLE;
                end
                ARMED: if (start_i) begin
                    state_d     = LOAD;
                    cnt_d       = '0;
                    frame_d     = '0;
                    key_d       = '0;
                    key_valid_d = 1'b0;
                end
                LOCKOUT: begin
                    key_d       = '0;
                    key_valid_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_q     <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
        end
    end
endmodule

// File: tb/tb_c499_key_loader.sv
// tb_c499_key_loader: frame table plus scoreboard of expected verdicts, with hand sequences for clear/lockout
module tb_c499_key_loader;
    logic        clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, clear_i = 1'b0;
    logic        bit_valid_i = 1'b0, bit_data_i = 1'b0;
    logic        bit_ready_o, key_valid_o, busy_o, err_o, lockout_o;
    logic [3:0]  key_p_o, fail_cnt_o;
    logic [22:0] key_x_o;
    int          vectors = 0, miscompares = 0;

    typedef struct {
        logic [26:0] key;
        logic [7:0]  chk;
        bit          gaps;
        bit          ok;
        logic [3:0]  fail;
        bit          lock;
    } vec_t;

    vec_t tbl[8];
    vec_t sb[$];

    always #5 clk_i = ~clk_i;

    c499_key_loader dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
        .bit_valid_i(bit_valid_i), .bit_data_i(bit_data_i), .bit_ready_o(bit_ready_o),
        .key_p_o(key_p_o), .key_x_o(key_x_o), .key_valid_o(key_valid_o), .busy_o(busy_o),
        .err_o(err_o), .lockout_o(lockout_o), .fail_cnt_o(fail_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input vec_t v);
        logic [34:0] frame;
        frame = {v.chk, v.key};
        sb.push_back(v);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("ready_after_start", 32'(bit_ready_o), 32'd1);
        check("kv_low_in_load", 32'(key_valid_o), 32'd0);
        check("keys_zero_in_load", 32'({key_p_o, key_x_o}), 32'd0);
        for (int i = 0; i < 35; i++) begin
            if (v.gaps && $urandom_range(0, 1) == 1) begin
                bit_valid_i = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk_i);
            end
            bit_valid_i = 1'b1;
            bit_data_i  = frame[i];
            @(negedge clk_i);
        end
        bit_valid_i = 1'b0;
    endtask

    task automatic wait_result();
        vec_t e;
        int   lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            if (key_valid_o || err_o) lat = c;
            else @(negedge clk_i);
        end
        e = sb.pop_front();
        check("result_latency", 32'(lat), 32'd2);
        check("key_valid", 32'(key_valid_o), 32'(e.ok));
        check("err_pulse", 32'(err_o), 32'(!e.ok));
        check("key_p", 32'(key_p_o), e.ok ? 32'(e.key[3:0]) : 32'd0);
        check("key_x", 32'(key_x_o), e.ok ? 32'(e.key[26:4]) : 32'd0);
        check("fail_cnt", 32'(fail_cnt_o), 32'(e.fail));
        check("lockout", 32'(lockout_o), 32'(e.lock));
        @(negedge clk_i);
        check("err_one_cycle", 32'(err_o), 32'd0);
        check("kv_hold", 32'(key_valid_o), 32'(e.ok));
        check("not_busy_after", 32'({busy_o, bit_ready_o}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{27'h0000001, 8'h01, 1'b0, 1'b1, 4'd0, 1'b0};
        tbl[1] = '{27'h7FFFFFF, 8'hF8, 1'b1, 1'b1, 4'd0, 1'b0};
        tbl[2] = '{27'h7FFFFFF, 8'h00, 1'b0, 1'b0, 4'd1, 1'b0};
        tbl[3] = '{27'h1234567, 8'h00, 1'b1, 1'b1, 4'd0, 1'b0};
        tbl[4] = '{27'h7FFFFFF, 8'h00, 1'b0, 1'b0, 4'd1, 1'b0};
        tbl[5] = '{27'h0000001, 8'h00, 1'b1, 1'b0, 4'd2, 1'b0};
        tbl[6] = '{27'h1234567, 8'hFF, 1'b0, 1'b0, 4'd3, 1'b1};
        tbl[7] = '{27'h0000000, 8'h55, 1'b0, 1'b0, 4'd1, 1'b0};
        repeat (2) @(negedge clk_i);
        check("reset_keys", 32'({key_p_o, key_x_o}), 32'd0);
        check("reset_flags", 32'({bit_ready_o, key_valid_o, busy_o, err_o, lockout_o, fail_cnt_o}), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i]);
            wait_result();
        end
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("lock_ignores_start", 32'({lockout_o, bit_ready_o, busy_o}), 32'b100);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("lock_ignores_clear", 32'({lockout_o, fail_cnt_o}), 32'h13);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("lock_reset_keys", 32'({key_p_o, key_x_o}), 32'd0);
        check("lock_reset_flags", 32'({bit_ready_o, key_valid_o, busy_o, err_o, lockout_o, fail_cnt_o}), 32'd0);
        @(negedge clk_i);
        send_frame(tbl[7]);
        wait_result();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_valid_i = 1'b1;
            bit_data_i  = 1'b1;
            @(negedge clk_i);
        end
        bit_valid_i = 1'b0;
        clear_i     = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("clear_drops_ready", 32'({bit_ready_o, busy_o, key_valid_o}), 32'd0);
        check("clear_keeps_fail", 32'(fail_cnt_o), 32'd1);
        send_frame(tbl[0]);
        wait_result();
        start_i = 1'b1;
        clear_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        clear_i = 1'b0;
        check("start_clear_idle", 32'({key_valid_o, bit_ready_o, busy_o}), 32'd0);
        check("start_clear_keys", 32'({key_p_o, key_x_o}), 32'd0);
        send_frame(tbl[3]);
        wait_result();
        send_frame(tbl[1]);
        wait_result();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
